// File: rtl/qpu_exu_evt_queue_pkg.sv
// Shared sizing for the EXU event queue; each value can be overridden from the global QPU defines.
// Optional feature macro used by this slice: QPU_EVTQ_LATE_CNT_EN.
`ifndef QPU_EVTQ_DEPTH
`define QPU_EVTQ_DEPTH 4
`endif

`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 32
`endif

`ifndef QPU_EVENT_WIRE_WIDTH
`define QPU_EVENT_WIRE_WIDTH 16
`endif

`ifndef QPU_EVENT_NUM
`define QPU_EVENT_NUM 8
`endif

`ifndef QPU_EVTQ_LATE_CNT_W
`define QPU_EVTQ_LATE_CNT_W 16
`endif

package qpu_exu_evt_queue_pkg;

   localparam int EVTQ_DEPTH      = `QPU_EVTQ_DEPTH;
   localparam int EVTQ_TIME_W     = `QPU_TIME_WIDTH;
   localparam int EVTQ_EDATA_W    = `QPU_EVENT_WIRE_WIDTH;
   localparam int EVTQ_OPR_W      = `QPU_EVENT_NUM;
   localparam int EVTQ_LATE_CNT_W = `QPU_EVTQ_LATE_CNT_W;

endpackage

// File: rtl/qpu_exu_evt_queue_fifo.sv
// Generic synchronous FIFO with flush, occupancy count, full and empty.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module qpu_evtq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head payload reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/qpu_exu_evt_queue.sv
// Receives EXU timing-point / event write-backs and releases each event when the system timer reaches it.
// Optional late-issue counter enabled by defining QPU_EVTQ_LATE_CNT_EN.
module qpu_exu_evt_queue
    import qpu_exu_evt_queue_pkg::*;
#(
    parameter int DEPTH   = EVTQ_DEPTH,
    parameter int TIME_W  = EVTQ_TIME_W,
    parameter int EDATA_W = EVTQ_EDATA_W,
    parameter int OPR_W   = EVTQ_OPR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     twbck_i_valid,
    output logic                     twbck_i_ready,
    input  logic [TIME_W-1:0]        twbck_i_data,
    input  logic                     ewbck_i_valid,
    output logic                     ewbck_i_ready,
    input  logic [EDATA_W-1:0]       ewbck_i_data,
    input  logic [OPR_W-1:0]         ewbck_i_oprand,
    output logic                     evt_o_valid,
    input  logic                     evt_o_ready,
    output logic [TIME_W-1:0]        evt_o_time,
    output logic [EDATA_W-1:0]       evt_o_data,
    output logic [OPR_W-1:0]         evt_o_oprand,
    output logic                     evt_o_late,
    output logic [TIME_W-1:0]        sys_time_o,
    output logic [$clog2(DEPTH):0]   evtq_count
`ifdef QPU_EVTQ_LATE_CNT_EN
    ,
    output logic [EVTQ_LATE_CNT_W-1:0] late_cnt
`endif
);

    localparam int ENTRY_W = TIME_W + EDATA_W + OPR_W;

    logic [TIME_W-1:0]  sys_time;
    logic [TIME_W-1:0]  pending_ts;
    logic [TIME_W-1:0]  push_ts;
    logic [TIME_W-1:0]  head_ts;
    logic [TIME_W-1:0]  diff;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               rdy;
    logic               tw_hs;
    logic               ew_hs;
    logic               pop;
    logic               due;

    assign rdy           = ~full & ~flush;
    assign twbck_i_ready = rdy;
    assign ewbck_i_ready = rdy;
    assign tw_hs         = twbck_i_valid & rdy;
    assign ew_hs         = ewbck_i_valid & rdy;

    // An event paired with a timing point in the same cycle takes that new point, not the stale one.
    assign push_ts = tw_hs ? twbck_i_data : pending_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_time   <= '0;
            pending_ts <= '0;
        end else begin
            sys_time <= sys_time + TIME_W'(1);
            if (tw_hs) begin
                pending_ts <= twbck_i_data;
            end
        end
    end

    qpu_evtq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (ew_hs),
        .wdata ({push_ts, ewbck_i_data, ewbck_i_oprand}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (evtq_count)
    );

    // Modular distance: anything less than half the timer range behind "now" counts as due.
    assign head_ts = head[ENTRY_W-1 -: TIME_W];
    assign diff    = sys_time - head_ts;
    assign due     = ~diff[TIME_W-1];

    assign evt_o_valid  = ~empty & due & ~flush;
    assign evt_o_time   = head_ts;
    assign evt_o_data   = head[OPR_W +: EDATA_W];
    assign evt_o_oprand = head[OPR_W-1:0];
    assign evt_o_late   = evt_o_valid & (diff != '0);
    assign sys_time_o   = sys_time;
    assign pop          = evt_o_valid & evt_o_ready;

`ifdef QPU_EVTQ_LATE_CNT_EN
    // Saturating so a long run of late issues never wraps back to a misleadingly small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            late_cnt <= '0;
        end else if (pop && evt_o_late && (late_cnt != '1)) begin
            late_cnt <= late_cnt + EVTQ_LATE_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_qpu_exu_evt_queue.sv
// Scoreboard bench for qpu_exu_evt_queue with an 8-bit timer so timer wrap is reachable.
// Works with and without QPU_EVTQ_LATE_CNT_EN.
module tb_qpu_exu_evt_queue;

    localparam int DEPTH   = 4;
    localparam int TIME_W  = 8;
    localparam int EDATA_W = 16;
    localparam int OPR_W   = 8;

    typedef struct {
        logic [TIME_W-1:0]  ts;
        logic [EDATA_W-1:0] data;
        logic [OPR_W-1:0]   opr;
    } entry_t;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 twbck_i_valid;
    logic                 twbck_i_ready;
    logic [TIME_W-1:0]    twbck_i_data;
    logic                 ewbck_i_valid;
    logic                 ewbck_i_ready;
    logic [EDATA_W-1:0]   ewbck_i_data;
    logic [OPR_W-1:0]     ewbck_i_oprand;
    logic                 evt_o_valid;
    logic                 evt_o_ready;
    logic [TIME_W-1:0]    evt_o_time;
    logic [EDATA_W-1:0]   evt_o_data;
    logic [OPR_W-1:0]     evt_o_oprand;
    logic                 evt_o_late;
    logic [TIME_W-1:0]    sys_time_o;
    logic [$clog2(DEPTH):0] evtq_count;
`ifdef QPU_EVTQ_LATE_CNT_EN
    logic [15:0]          late_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    entry_t            sb[$];
    logic [TIME_W-1:0] m_time;
    logic [TIME_W-1:0] m_pending;
    logic [15:0]       m_late;
    logic              ew_hs_seen;

    qpu_exu_evt_queue #(
        .DEPTH   (DEPTH),
        .TIME_W  (TIME_W),
        .EDATA_W (EDATA_W),
        .OPR_W   (OPR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .twbck_i_valid  (twbck_i_valid),
        .twbck_i_ready  (twbck_i_ready),
        .twbck_i_data   (twbck_i_data),
        .ewbck_i_valid  (ewbck_i_valid),
        .ewbck_i_ready  (ewbck_i_ready),
        .ewbck_i_data   (ewbck_i_data),
        .ewbck_i_oprand (ewbck_i_oprand),
        .evt_o_valid    (evt_o_valid),
        .evt_o_ready    (evt_o_ready),
        .evt_o_time     (evt_o_time),
        .evt_o_data     (evt_o_data),
        .evt_o_oprand   (evt_o_oprand),
        .evt_o_late     (evt_o_late),
        .sys_time_o     (sys_time_o),
        .evtq_count     (evtq_count)
`ifdef QPU_EVTQ_LATE_CNT_EN
        ,
        .late_cnt       (late_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drives one cycle of write-back inputs from a negedge and returns at the next negedge.
    task automatic applyStimulus(input logic tv, input logic [TIME_W-1:0] td,
                                 input logic ev, input logic [EDATA_W-1:0] ed,
                                 input logic [OPR_W-1:0] eo, input logic fl);
        twbck_i_valid  = tv;
        twbck_i_data   = td;
        ewbck_i_valid  = ev;
        ewbck_i_data   = ed;
        ewbck_i_oprand = eo;
        flush          = fl;
        @(negedge clk);
        twbck_i_valid  = 1'b0;
        ewbck_i_valid  = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic waitTime(input logic [TIME_W-1:0] t);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (sys_time_o == t) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) checkOutput("wait_time_timeout", 32'(sys_time_o), 32'(t));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"},    32'(evt_o_valid),   32'd0);
        checkOutput({tag, "_twready"},  32'(twbck_i_ready), 32'd1);
        checkOutput({tag, "_ewready"},  32'(ewbck_i_ready), 32'd1);
        checkOutput({tag, "_sys_time"}, 32'(sys_time_o),    32'd0);
        checkOutput({tag, "_count"},    32'(evtq_count),    32'd0);
        checkOutput({tag, "_time"},     32'(evt_o_time),    32'd0);
        checkOutput({tag, "_data"},     32'(evt_o_data),    32'd0);
        checkOutput({tag, "_opr"},      32'(evt_o_oprand),  32'd0);
        checkOutput({tag, "_late"},     32'(evt_o_late),    32'd0);
`ifdef QPU_EVTQ_LATE_CNT_EN
        checkOutput({tag, "_late_cnt"}, 32'(late_cnt),      32'd0);
`endif
    endtask

    // Reference model: checks every settled cycle, then advances to what the next posedge should produce.
    initial begin
        logic              exp_ready;
        logic              exp_valid;
        logic              exp_late;
        logic [TIME_W-1:0] diff;
        entry_t            ent;
        m_time     = '0;
        m_pending  = '0;
        m_late     = '0;
        ew_hs_seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                sb.delete();
                m_time    = '0;
                m_pending = '0;
                m_late    = '0;
            end else begin
                exp_ready = (sb.size() < DEPTH) && !flush;
                diff      = '0;
                if (sb.size() > 0) diff = m_time - sb[0].ts;
                exp_valid = (sb.size() > 0) && !diff[TIME_W-1] && !flush;
                exp_late  = exp_valid && (diff != '0);

                checkOutput("sys_time", 32'(sys_time_o),    32'(m_time));
                checkOutput("count",    32'(evtq_count),    32'(sb.size()));
                checkOutput("twready",  32'(twbck_i_ready), 32'(exp_ready));
                checkOutput("ewready",  32'(ewbck_i_ready), 32'(exp_ready));
                checkOutput("valid",    32'(evt_o_valid),   32'(exp_valid));
                checkOutput("late",     32'(evt_o_late),    32'(exp_late));
`ifdef QPU_EVTQ_LATE_CNT_EN
                checkOutput("late_cnt", 32'(late_cnt),      32'(m_late));
`endif
                if (exp_valid) begin
                    checkOutput("evt_time", 32'(evt_o_time),   32'(sb[0].ts));
                    checkOutput("evt_data", 32'(evt_o_data),   32'(sb[0].data));
                    checkOutput("evt_opr",  32'(evt_o_oprand), 32'(sb[0].opr));
                end

                if (exp_valid && evt_o_ready) begin
                    if (exp_late && m_late != 16'hFFFF) m_late = m_late + 16'd1;
                    void'(sb.pop_front());
                end
                if (ewbck_i_valid && exp_ready) begin
                    ent.ts   = twbck_i_valid ? twbck_i_data : m_pending;
                    ent.data = ewbck_i_data;
                    ent.opr  = ewbck_i_oprand;
                    sb.push_back(ent);
                    ew_hs_seen = 1'b1;
                end
                if (twbck_i_valid && exp_ready) m_pending = twbck_i_data;
                if (flush) sb.delete();
                m_time = m_time + TIME_W'(1);
            end
        end
    end

    initial begin
        logic ok;
        rst_n          = 1'b0;
        flush          = 1'b0;
        twbck_i_valid  = 1'b0;
        twbck_i_data   = '0;
        ewbck_i_valid  = 1'b0;
        ewbck_i_data   = '0;
        ewbck_i_oprand = '0;
        evt_o_ready    = 1'b1;

        @(negedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] T1 ordered issue");
        waitTime(8'd3);
        applyStimulus(1'b1, 8'd10, 1'b1, 16'hE000, 8'h01, 1'b0);
        applyStimulus(1'b0, 8'd0,  1'b1, 16'hE001, 8'h02, 1'b0);
        waitTime(8'd12);

        $display("[TB] T2 backpressure");
        waitTime(8'd15);
        applyStimulus(1'b1, 8'd20, 1'b1, 16'hE002, 8'h04, 1'b0);
        waitTime(8'd20);
        evt_o_ready = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t2_hold_end_time", 32'(sys_time_o), 32'd25);
        evt_o_ready = 1'b1;
        @(negedge clk);

        $display("[TB] T3 full");
        waitTime(8'd40);
        applyStimulus(1'b1, 8'd100, 1'b1, 16'hE010, 8'h10, 1'b0);
        applyStimulus(1'b0, 8'd0,   1'b1, 16'hE011, 8'h11, 1'b0);
        applyStimulus(1'b0, 8'd0,   1'b1, 16'hE012, 8'h12, 1'b0);
        applyStimulus(1'b0, 8'd0,   1'b1, 16'hE013, 8'h13, 1'b0);
        ew_hs_seen     = 1'b0;
        ewbck_i_valid  = 1'b1;
        ewbck_i_data   = 16'hE014;
        ewbck_i_oprand = 8'h14;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ew_hs_seen) ok = 1'b1;
        end
        ewbck_i_valid = 1'b0;
        if (!ok) checkOutput("t3_stall_timeout", 32'd0, 32'd1);
        checkOutput("t3_release_time", 32'(sys_time_o), 32'd102);
        waitTime(8'd110);

        $display("[TB] T4 timer wrap");
        waitTime(8'd250);
        applyStimulus(1'b1, 8'd4, 1'b1, 16'hE020, 8'h20, 1'b0);
        waitTime(8'd8);

        $display("[TB] T5 flush");
        waitTime(8'd20);
        evt_o_ready = 1'b0;
        applyStimulus(1'b1, 8'd22, 1'b1, 16'hE030, 8'h30, 1'b0);
        applyStimulus(1'b0, 8'd0,  1'b1, 16'hE031, 8'h31, 1'b0);
        applyStimulus(1'b0, 8'd0,  1'b1, 16'hE032, 8'h32, 1'b0);
        applyStimulus(1'b0, 8'd0,  1'b1, 16'hE033, 8'h33, 1'b1);
        evt_o_ready = 1'b1;
        applyStimulus(1'b0, 8'd0,  1'b1, 16'hE034, 8'h34, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] T6 reset mid-run");
        waitTime(8'd40);
        applyStimulus(1'b1, 8'd90, 1'b1, 16'hE040, 8'h40, 1'b0);
        applyStimulus(1'b0, 8'd0,  1'b1, 16'hE041, 8'h41, 1'b0);
        @(negedge clk);
        checkOutput("t6_queued", 32'(evtq_count), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
